// File: rtl/axi4_id_compressor.sv
// AXI4 ID-width adapter: wide upstream IDs are folded onto a small pool of downstream
// slots per direction and the original ID is restored on the B/R responses.

module axi4_id_slot_table #(
    parameter int IN_ID_W  = 12,
    parameter int OUT_ID_W = 6,
    parameter int MAX_OUT  = 8,
    parameter int CNT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    input  logic [IN_ID_W-1:0]  req_id,
    input  logic                down_ready,
    output logic                down_valid,
    output logic                up_ready,
    output logic [OUT_ID_W-1:0] req_slot,
    input  logic                rsp_valid,
    input  logic                rsp_ready,
    input  logic [OUT_ID_W-1:0] rsp_slot,
    input  logic                rsp_retire,
    output logic [IN_ID_W-1:0]  rsp_id,
    output logic                rsp_unalloc,
    output logic                full
);
    localparam int SLOTS = 1 << OUT_ID_W;

    logic [SLOTS-1:0]    alloc_r;
    logic [IN_ID_W-1:0]  in_id_r [SLOTS];
    logic [CNT_W-1:0]    cnt_r   [SLOTS];

    logic [SLOTS-1:0]    match_s;
    logic [SLOTS-1:0]    inc_s;
    logic [SLOTS-1:0]    dec_s;
    logic                hit_s;
    logic                free_s;
    logic                map_ok_s;
    logic                accept_s;
    logic                rsp_hs_s;
    logic [OUT_ID_W-1:0] hit_idx_s;
    logic [OUT_ID_W-1:0] free_idx_s;

    function automatic logic [OUT_ID_W-1:0] lowest_set(input logic [SLOTS-1:0] vec);
        lowest_set = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = OUT_ID_W'(i);
        end
    endfunction

    // Which allocated slots already own the requested upstream ID
    always_comb begin
        match_s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            match_s[i] = alloc_r[i] && (in_id_r[i] == req_id);
        end
    end

    // Per-slot accept / retire strobes
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            inc_s[i] = accept_s && (req_slot == OUT_ID_W'(i));
            dec_s[i] = rsp_hs_s && rsp_retire && alloc_r[i] && (rsp_slot == OUT_ID_W'(i));
        end
    end

    // A hit always reuses its slot, even when saturated, so same-ID ordering holds
    assign hit_s       = |match_s;
    assign free_s      = ~(&alloc_r);
    assign hit_idx_s   = lowest_set(match_s);
    assign free_idx_s  = lowest_set(~alloc_r);
    assign req_slot    = hit_s ? hit_idx_s : free_idx_s;
    assign map_ok_s    = hit_s ? (cnt_r[hit_idx_s] < CNT_W'(MAX_OUT)) : free_s;
    assign down_valid  = reset_n & req_valid & map_ok_s;
    assign up_ready    = reset_n & down_ready & map_ok_s;
    assign accept_s    = down_valid & down_ready;
    assign rsp_hs_s    = reset_n & rsp_valid & rsp_ready;
    assign rsp_id      = alloc_r[rsp_slot] ? in_id_r[rsp_slot] : '0;
    assign rsp_unalloc = rsp_hs_s & ~alloc_r[rsp_slot];
    assign full        = &alloc_r;

    // Slot table: allocate on first accept, count outstanding, free on final retire
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alloc_r <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                in_id_r[i] <= '0;
                cnt_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (inc_s[i] && !dec_s[i]) begin
                    if (alloc_r[i]) begin
                        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    end else begin
                        alloc_r[i] <= 1'b1;
                        in_id_r[i] <= req_id;
                        cnt_r[i]   <= CNT_W'(1);
                    end
                end else if (dec_s[i] && !inc_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                    if (cnt_r[i] == CNT_W'(1)) alloc_r[i] <= 1'b0;
                end
            end
        end
    end
endmodule

module axi4_id_compressor #(
    parameter int IN_ID_W  = 12,
    parameter int OUT_ID_W = 6,
    parameter int MAX_OUT  = 8,
    parameter int A_W      = 43,
    parameter int R_W      = 66
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_in_aw_valid,
    output logic                io_in_aw_ready,
    input  logic [IN_ID_W-1:0]  io_in_aw_id,
    input  logic [A_W-1:0]      io_in_aw_bits,
    output logic                io_out_aw_valid,
    input  logic                io_out_aw_ready,
    output logic [OUT_ID_W-1:0] io_out_aw_id,
    output logic [A_W-1:0]      io_out_aw_bits,
    input  logic                io_out_b_valid,
    output logic                io_out_b_ready,
    input  logic [OUT_ID_W-1:0] io_out_b_id,
    input  logic [1:0]          io_out_b_resp,
    output logic                io_in_b_valid,
    input  logic                io_in_b_ready,
    output logic [IN_ID_W-1:0]  io_in_b_id,
    output logic [1:0]          io_in_b_resp,
    input  logic                io_in_ar_valid,
    output logic                io_in_ar_ready,
    input  logic [IN_ID_W-1:0]  io_in_ar_id,
    input  logic [A_W-1:0]      io_in_ar_bits,
    output logic                io_out_ar_valid,
    input  logic                io_out_ar_ready,
    output logic [OUT_ID_W-1:0] io_out_ar_id,
    output logic [A_W-1:0]      io_out_ar_bits,
    input  logic                io_out_r_valid,
    output logic                io_out_r_ready,
    input  logic [OUT_ID_W-1:0] io_out_r_id,
    input  logic                io_out_r_last,
    input  logic [R_W-1:0]      io_out_r_bits,
    output logic                io_in_r_valid,
    input  logic                io_in_r_ready,
    output logic [IN_ID_W-1:0]  io_in_r_id,
    output logic                io_in_r_last,
    output logic [R_W-1:0]      io_in_r_bits,
    output logic                io_err,
    output logic                io_wr_full,
    output logic                io_rd_full
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic b_unalloc_s;
    logic r_unalloc_s;
    logic err_r;

    axi4_id_slot_table #(
        .IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) u_wr_table (
        .clk(clk), .reset_n(reset_n),
        .req_valid(io_in_aw_valid), .req_id(io_in_aw_id), .down_ready(io_out_aw_ready),
        .down_valid(io_out_aw_valid), .up_ready(io_in_aw_ready), .req_slot(io_out_aw_id),
        .rsp_valid(io_out_b_valid), .rsp_ready(io_in_b_ready), .rsp_slot(io_out_b_id),
        .rsp_retire(1'b1), .rsp_id(io_in_b_id), .rsp_unalloc(b_unalloc_s), .full(io_wr_full)
    );

    axi4_id_slot_table #(
        .IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) u_rd_table (
        .clk(clk), .reset_n(reset_n),
        .req_valid(io_in_ar_valid), .req_id(io_in_ar_id), .down_ready(io_out_ar_ready),
        .down_valid(io_out_ar_valid), .up_ready(io_in_ar_ready), .req_slot(io_out_ar_id),
        .rsp_valid(io_out_r_valid), .rsp_ready(io_in_r_ready), .rsp_slot(io_out_r_id),
        .rsp_retire(io_out_r_last), .rsp_id(io_in_r_id), .rsp_unalloc(r_unalloc_s),
        .full(io_rd_full)
    );

    assign io_out_aw_bits = io_in_aw_bits;
    assign io_out_ar_bits = io_in_ar_bits;
    assign io_in_b_valid  = reset_n & io_out_b_valid;
    assign io_out_b_ready = reset_n & io_in_b_ready;
    assign io_in_b_resp   = io_out_b_resp;
    assign io_in_r_valid  = reset_n & io_out_r_valid;
    assign io_out_r_ready = reset_n & io_in_r_ready;
    assign io_in_r_last   = io_out_r_last;
    assign io_in_r_bits   = io_out_r_bits;
    assign io_err         = err_r;

    // Sticky error on any response handshake that lands on an unallocated slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (b_unalloc_s || r_unalloc_s) begin
            err_r <= 1'b1;
        end
    end
endmodule

// File: doc/axi4_id_compressor.md
Name: axi4_id_compressor

Overview:
Parametrised AXI4 ID-width adapter between a wide-ID master (PS general-purpose port, simulation host) and a narrow-ID slave (HP/DDR port, target memory model).
- Remaps each in-flight upstream ID onto a free downstream ID slot and restores the original ID on the B/R responses.
- Read and write directions each have their own independent slot table.
- The W channel carries no ID and is wired around this block.

Parameters:
IN_ID_W, 12, upstream ID width
OUT_ID_W, 6, downstream ID width; slots per direction SLOTS = 2^OUT_ID_W
MAX_OUT, 8, max outstanding transactions per slot (counter width CNT_W = clog2(MAX_OUT+1))
A_W, 43, bundled AR/AW payload width (addr 32 + len 8 + size 3), passed untouched
R_W, 66, bundled R payload width excluding last (data 64 + resp 2), passed untouched

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous active-low reset
io_in_aw_valid/io_in_aw_ready  in/out  1  upstream AW handshake
io_in_aw_id  in  IN_ID_W  upstream AW ID
io_in_aw_bits  in  A_W  AW payload
io_out_aw_valid/io_out_aw_ready  out/in  1  downstream AW handshake
io_out_aw_id  out  OUT_ID_W  slot index
io_out_aw_bits  out  A_W  = io_in_aw_bits
io_out_b_valid/io_out_b_ready  in/out  1  downstream B handshake
io_out_b_id  in  OUT_ID_W  downstream B ID
io_out_b_resp  in  2  B response
io_in_b_valid/io_in_b_ready  out/in  1  upstream B handshake
io_in_b_id  out  IN_ID_W  restored B ID
io_in_b_resp  out  2  B response
io_in_ar_*, io_out_ar_*  —  —  same as AW
io_out_r_valid/io_out_r_ready  in/out  1  downstream R handshake
io_out_r_id  in  OUT_ID_W  downstream R ID
io_out_r_last  in  1  R last beat
io_out_r_bits  in  R_W  R payload
io_in_r_valid/io_in_r_ready  out/in  1  upstream R handshake
io_in_r_id  out  IN_ID_W  restored R ID
io_in_r_last  out  1  R last beat
io_in_r_bits  out  R_W  R payload
io_err  out  1  sticky: response arrived on an unallocated slot
io_wr_full, io_rd_full  out  1  no slot available for a new ID in that direction

Behaviour:
- Slot state: per direction, SLOTS entries of {alloc, in_id[IN_ID_W], cnt[CNT_W]}.
- Reset (reset_n=0 at a clk edge): all alloc=0, cnt=0, io_err=0. While reset_n=0 all valid/ready outputs are forced to 0.
- Request mapping is combinational from the registered table only:
  - hit: an alloc slot has in_id == request ID. Use that slot. If its cnt == MAX_OUT, the request stalls; it is never placed in a second slot (preserves AXI same-ID ordering).
  - miss: use the lowest-index slot with alloc=0. If none exists, the request stalls.
  - map_ok = hit with cnt < MAX_OUT, or miss with a free slot present.
- Request handshake, zero latency:
  - io_out_x_valid = io_in_x_valid & map_ok
  - io_in_x_ready = io_out_x_ready & map_ok
  - io_out_x_id = slot index; payload passes through unchanged
  - io_out_x_valid never depends on io_out_x_ready.
- Accept (downstream valid&ready):
  - miss: alloc<=1, in_id<=ID, cnt<=1
  - hit: cnt<=cnt+1
- Response path, zero latency:
  - io_in_b/r_id = in_id of slot[io_out_b/r_id]
  - valid, ready and payload pass straight through.
- Retire:
  - B handshake: cnt-1.
  - R handshake with last=1: cnt-1. Non-last R beats do not change cnt.
  - When cnt reaches 0, alloc<=0.
- Simultaneous accept and retire on the same slot in one cycle: cnt unchanged, slot stays allocated.
- A slot freed in cycle N is allocatable no earlier than cycle N+1.
- Response on a slot with alloc=0:
  - passes through with io_in_x_id = 0
  - cnt is not decremented (no underflow)
  - io_err<=1, held until reset.
- io_wr_full / io_rd_full = every slot in that direction has alloc=1. Registered-state view, combinational output.
- Read and write tables are fully independent; the same upstream ID may occupy a slot in each.

Test Plan:
- Reset, then AW id=0x123 with out_ready=1 -> out_aw_id=0, slot0 {alloc,0x123,cnt1}; B on id 0 -> in_b_id=0x123, slot0 freed next cycle.
- Three ARs id=0x5 back-to-back, then two ARs id=0x7 -> 0x5 all on slot0 (cnt3), 0x7 on slot1 (cnt2); R burst len 4 on slot0 decrements cnt only on the last beat (3->2).
- MAX_OUT=8: nine AWs id=0xA with no B returned -> 9th stalls (in_aw_ready=0, out_aw_valid=0); one B returned -> 9th accepted the following cycle on slot0.
- OUT_ID_W=2: four distinct read IDs allocated -> io_rd_full=1 and a 5th new ID stalls; the 5th never maps to a freed slot in the same cycle that slot retires.
- Same cycle AW accept and B retire on slot3 with cnt=1 -> cnt stays 1, alloc stays 1, upstream ID unchanged.
- B with id=2 while slot2 unallocated -> in_b_id=0, io_err=1 sticky; reset_n=0 for one cycle mid-burst -> all slots cleared, io_err=0, all valids 0.
